// File: rtl/baud_pkg.sv
// -----------------------------------------------------------------------------
// baud_pkg
// Shared constants and types for the UART baud-timing controller.
//   BAUD_DIV_W       default width of divisors and counters
//   BAUD_DEFAULT_DIV divisor in force after reset (clock cycles per bit)
//   BAUD_MIN_DIV     smallest divisor the controller will accept
//   state_e          main FSM states
//   div_t            divisor type at the default width
// -----------------------------------------------------------------------------
package baud_pkg;

    localparam int BAUD_DIV_W       = 16;
    localparam int BAUD_DEFAULT_DIV = 5208;
    localparam int BAUD_MIN_DIV     = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef logic [BAUD_DIV_W-1:0] div_t;

endpackage

// File: rtl/baud_phase_cnt.sv
// -----------------------------------------------------------------------------
// baud_phase_cnt
// Auto-reloading down-counter used for both the TX bit timer and the RX
// sample timer. The count runs load_val_i..0; the edge on which it sits at 0
// while enabled is the terminal edge, flagged combinationally on tc_o and
// followed by a reload from load_val_i.
//   clk_i, rst_i  clock, asynchronous active-high reset
//   clr_i         force count to 0 (highest priority)
//   load_i        load load_val_i
//   en_i          count down / reload on terminal
//   load_val_i    load and reload value
//   tc_o          high when this edge is a terminal edge
// -----------------------------------------------------------------------------
module baud_phase_cnt #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic         en_i,
    input  logic [W-1:0] load_val_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q, cnt_d;

    assign tc_o = en_i && !clr_i && !load_i && (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i || tc_o) begin
            cnt_d = load_val_i;
        end else if (en_i) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/baud_ctrl.sv
// -----------------------------------------------------------------------------
// baud_ctrl
// Programmable baud-timing controller. Generates a free-running TX bit tick
// and an RX mid-bit sample tick that re-phases on each start-bit detect.
// The divisor is loaded at run time through a valid/ready handshake and is
// applied only at a TX bit boundary so no TX bit is ever shortened.
//   clk_i, rst_i        clock, asynchronous active-high reset
//   en_i                1 = generate ticks, 0 = idle
//   cfg_valid_i/cfg_div_i/cfg_ready_o  divisor handshake
//   cfg_err_o           pulse: accepted divisor < MIN_DIV was discarded
//   rx_sync_i           pulse: start-bit edge seen, re-phase RX sampling
//   rx_stop_i           pulse: frame done, stop RX sampling
//   tx_tick_o           one-cycle TX bit strobe
//   rx_sample_o         one-cycle RX sample strobe
//   running_o           FSM in RUN
//   div_active_o        divisor currently in force
// -----------------------------------------------------------------------------
module baud_ctrl
    import baud_pkg::*;
#(
    parameter int DIV_W       = BAUD_DIV_W,
    parameter int DEFAULT_DIV = BAUD_DEFAULT_DIV,
    parameter int MIN_DIV     = BAUD_MIN_DIV
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             cfg_valid_i,
    input  logic [DIV_W-1:0] cfg_div_i,
    output logic             cfg_ready_o,
    output logic             cfg_err_o,
    input  logic             rx_sync_i,
    input  logic             rx_stop_i,
    output logic             tx_tick_o,
    output logic             rx_sample_o,
    output logic             running_o,
    output logic [DIV_W-1:0] div_active_o
);

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_active_q, div_active_d;
    logic [DIV_W-1:0] pend_div_q, pend_div_d;
    logic             pending_q, pending_d;
    logic             cfg_err_q, cfg_err_d;
    logic             rx_act_q, rx_act_d;
    logic             tx_tick_q, rx_sample_q;

    logic             run;
    logic             xfer, div_legal, apply, rx_sync_acc;
    logic             tx_tc, rx_tc;
    logic [DIV_W-1:0] tx_load_val, rx_load_val;

    assign run       = (state_q == RUN);
    assign state_d   = en_i ? RUN : IDLE;

    // Config handshake: one slot, ready whenever nothing is waiting to apply.
    assign xfer      = cfg_valid_i && !pending_q;
    assign div_legal = (cfg_div_i >= DIV_W'(MIN_DIV));

    // A waiting divisor lands immediately when idle, otherwise on the TX
    // terminal edge so the current bit keeps its full length.
    assign apply        = pending_q && (!run || tx_tc);
    assign div_active_d = apply ? pend_div_q : div_active_q;

    // The TX timer is loaded with the divisor that will be in force after
    // this edge, so a start or reload coinciding with apply uses the new value.
    assign tx_load_val = div_active_d - DIV_W'(1);

    always_comb begin
        pending_d  = pending_q;
        pend_div_d = pend_div_q;
        if (xfer && div_legal) begin
            pending_d  = 1'b1;
            pend_div_d = cfg_div_i;
        end else if (apply) begin
            pending_d  = 1'b0;
        end
    end

    assign cfg_err_d = xfer && !div_legal;

    // RX phase: sync wins over stop; dropping en also ends the phase.
    assign rx_sync_acc = run && en_i && rx_sync_i;

    always_comb begin
        rx_act_d = rx_act_q;
        if (rx_sync_acc) begin
            rx_act_d = 1'b1;
        end else if (rx_stop_i || !en_i) begin
            rx_act_d = 1'b0;
        end
    end

    // Sample strobe is registered, so the first terminal must fall one edge
    // before the half-bit point: load floor(D/2)-1. Reloads give period D.
    assign rx_load_val = rx_sync_acc ? ((div_active_q >> 1) - DIV_W'(1))
                                     : (div_active_q - DIV_W'(1));

    baud_phase_cnt #(.W(DIV_W)) u_tx_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (!en_i),
        .load_i     (en_i && !run),
        .en_i       (en_i && run),
        .load_val_i (tx_load_val),
        .tc_o       (tx_tc)
    );

    baud_phase_cnt #(.W(DIV_W)) u_rx_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (!rx_act_d),
        .load_i     (rx_sync_acc),
        .en_i       (rx_act_q),
        .load_val_i (rx_load_val),
        .tc_o       (rx_tc)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            div_active_q <= DIV_W'(DEFAULT_DIV);
            pend_div_q   <= '0;
            pending_q    <= 1'b0;
            cfg_err_q    <= 1'b0;
            rx_act_q     <= 1'b0;
            tx_tick_q    <= 1'b0;
            rx_sample_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_active_q <= div_active_d;
            pend_div_q   <= pend_div_d;
            pending_q    <= pending_d;
            cfg_err_q    <= cfg_err_d;
            rx_act_q     <= rx_act_d;
            tx_tick_q    <= tx_tc;
            rx_sample_q  <= rx_tc;
        end
    end

    assign cfg_ready_o  = !pending_q;
    assign cfg_err_o    = cfg_err_q;
    assign tx_tick_o    = tx_tick_q;
    assign rx_sample_o  = rx_sample_q;
    assign running_o    = run;
    assign div_active_o = div_active_q;

endmodule
